// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between fifo_sync_8x8 and the UART transmitter.
// The consumer (transmitter) is the master: it issues pops and reads data.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_d_out;
  logic       fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_d_out
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_d_out
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a registered-read FIFO and serialises each one as a UART
// frame: start bit, 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done,
  output logic [15:0]           frames_sent
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);
  // byte_done is registered, so it is raised one cycle before the last stop cycle.
  localparam logic [15:0] PenCnt  = 16'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic        tx_q;
  logic        rd_en_q;
  logic        busy_q;
  logic        byte_done_q;
  logic [15:0] frames_q;

  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign byte_done       = byte_done_q;
  assign frames_sent     = frames_q;

  // Frame sequencer; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      frames_q    <= 16'd0;
    end else begin
      rd_en_q     <= 1'b0;
      byte_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_en && !fifo.fifo_empty) begin
            state_q <= StPop;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StPop: begin
          state_q <= StLoad;
        end
        StLoad: begin
          // Read data is valid only now, one cycle after the pop.
          shift_q  <= fifo.fifo_d_out;
          parity_q <= ^fifo.fifo_d_out;
          cnt_q    <= 16'd0;
          tx_q     <= 1'b0;
          state_q  <= StStart;
        end
        StStart: begin
          if (cnt_q == LastCnt) begin
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StData: begin
          if (cnt_q == LastCnt) begin
            cnt_q <= 16'd0;
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StParity: begin
          if (cnt_q == LastCnt) begin
            cnt_q   <= 16'd0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StStop: begin
          if (cnt_q == PenCnt) begin
            byte_done_q <= 1'b1;
          end
          if (cnt_q == LastCnt) begin
            cnt_q    <= 16'd0;
            frames_q <= frames_q + 16'd1;
            if (tx_en && !fifo.fifo_empty) begin
              state_q <= StPop;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Runs two transmitters (no parity / even parity) side by side against a
// frame-timeline reference model and a small registered-read FIFO model.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic        clk;
  logic        rst;
  logic        tx_en;
  logic [1:0]  empty_s;
  logic [1:0]  rd_en_s;
  logic [1:0]  tx_s;
  logic [1:0]  busy_s;
  logic [1:0]  bd_s;
  logic [1:0][15:0] fs_s;
  logic [7:0]  dout_s [2];

  logic [7:0]  mem [2][512];
  int          wr_ptr [2];
  int          hw_ptr [2];
  int          ref_ptr [2];
  int          ref_off [2];
  int          ref_cnt [2];
  logic [7:0]  ref_byte [2];
  bit          hold [2];
  bit          chk_en;

  int n_cmp;
  int n_err;

  fifo_uart_tx_if fifo0 ();
  fifo_uart_tx_if fifo1 ();

  assign empty_s[0]       = (hw_ptr[0] == wr_ptr[0]);
  assign empty_s[1]       = (hw_ptr[1] == wr_ptr[1]);
  assign fifo0.fifo_empty = empty_s[0];
  assign fifo1.fifo_empty = empty_s[1];
  assign fifo0.fifo_d_out = dout_s[0];
  assign fifo1.fifo_d_out = dout_s[1];
  assign rd_en_s[0]       = fifo0.fifo_rd_en;
  assign rd_en_s[1]       = fifo1.fifo_rd_en;

  fifo_uart_tx #(
    .CLKS_PER_BIT (C),
    .PARITY_EN    (0)
  ) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .fifo        (fifo0.master),
    .tx          (tx_s[0]),
    .busy        (busy_s[0]),
    .byte_done   (bd_s[0]),
    .frames_sent (fs_s[0])
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT (C),
    .PARITY_EN    (1)
  ) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .fifo        (fifo1.master),
    .tx          (tx_s[1]),
    .busy        (busy_s[1]),
    .byte_done   (bd_s[1]),
    .frames_sent (fs_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Line level of frame bit k: start, data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par != 0 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Per-cycle check of one channel, then advance the FIFO and reference model
  // across the coming clock edge.
  task automatic chk_cycle(input int ch);
    int         flen;
    logic       avail;
    logic       e_tx;
    logic [3:0] exp_o;
    logic [3:0] got_o;
    // Timeline: POP at offset 0, LOAD at 1, then (10+parity) bits of C cycles.
    flen = 2 + (10 + ch) * C;
    if (ref_off[ch] < 2) e_tx = 1'b1;
    else e_tx = frame_bit(ref_byte[ch], ch, (ref_off[ch] - 2) / C);
    exp_o = {e_tx, ref_off[ch] == 0, ref_off[ch] >= 0, ref_off[ch] == flen - 1};
    got_o = {tx_s[ch], rd_en_s[ch], busy_s[ch], bd_s[ch]};
    check_eq($sformatf("ch%0d.tx_rd_busy_done", ch), 32'(got_o), 32'(exp_o));
    check_eq($sformatf("ch%0d.frames_sent", ch), 32'(fs_s[ch]), 32'(ref_cnt[ch] % 65536));

    avail = (hw_ptr[ch] != wr_ptr[ch]);
    // FIFO read port: data appears after a pop, held one cycle, garbage otherwise.
    if (rd_en_s[ch] === 1'b1) begin
      if (avail) begin
        dout_s[ch] = mem[ch][hw_ptr[ch] % 512];
        hw_ptr[ch]++;
      end
      hold[ch] = 1'b1;
    end else if (hold[ch]) begin
      hold[ch] = 1'b0;
    end else begin
      dout_s[ch] = 8'($urandom);
    end

    if (rst) begin
      ref_off[ch] = -1;
      ref_cnt[ch] = 0;
    end else begin
      if (ref_off[ch] == flen - 1) begin
        ref_cnt[ch]++;
        ref_off[ch] = -1;
      end else if (ref_off[ch] >= 0) begin
        ref_off[ch]++;
      end
      if (ref_off[ch] < 0 && tx_en && avail) begin
        ref_off[ch]  = 0;
        ref_byte[ch] = mem[ch][ref_ptr[ch] % 512];
        ref_ptr[ch]++;
      end
    end
  endtask

  // Outputs are sampled mid-cycle; inputs change just after the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int ch = 0; ch < 2; ch++) begin
        chk_cycle(ch);
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    for (int ch = 0; ch < 2; ch++) begin
      mem[ch][wr_ptr[ch] % 512] = b;
      wr_ptr[ch]++;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int   k;
    logic done;
    k    = 0;
    done = 1'b0;
    while (!done && k < max_cycles) begin
      cycle(1);
      k++;
      done = (ref_off[0] < 0) && (ref_off[1] < 0) &&
             (hw_ptr[0] == wr_ptr[0]) && (hw_ptr[1] == wr_ptr[1]);
    end
    check_eq("drain", 32'(done), 32'd1);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    tx_en  = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      wr_ptr[ch]   = 0;
      hw_ptr[ch]   = 0;
      ref_ptr[ch]  = 0;
      ref_off[ch]  = -1;
      ref_cnt[ch]  = 0;
      ref_byte[ch] = 8'd0;
      hold[ch]     = 1'b0;
      dout_s[ch]   = 8'd0;
    end

    // Reset held for three edges with a byte waiting and tx_en high.
    push(8'hA5);
    @(posedge clk);
    #1 chk_en = 1'b1;
    cycle(2);
    rst = 1'b0;
    wait_idle(400);

    // Three queued bytes go out back to back.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_idle(600);

    // Parity cases: 0x07 (parity 1) and 0x03 (parity 0).
    push(8'h07);
    push(8'h03);
    wait_idle(400);

    // tx_en dropped mid-frame: frame finishes, second byte stays queued.
    push(8'h11);
    push(8'h22);
    cycle(12);
    tx_en = 1'b0;
    cycle(120);
    tx_en = 1'b1;
    wait_idle(400);

    // One-cycle reset around data bit 3 of the first frame.
    push(8'h5A);
    push(8'h3C);
    cycle(19);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    wait_idle(400);

    // Random traffic, enable toggling and occasional resets.
    for (int it = 0; it < 30; it++) begin
      int n;
      n = int'($urandom_range(0, 3));
      for (int j = 0; j < n; j++) push(8'($urandom));
      tx_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
      end
      cycle(int'($urandom_range(1, 60)));
    end
    tx_en = 1'b1;
    wait_idle(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
